// File: rtl/platform_field_if.sv
// rtl/platform_field_if.sv - frame control inputs and committed platform outputs of platform_field
interface platform_field_if #(
  parameter int N_PLAT = 8
);
  logic                   frame_clk;
  logic                   hold;
  logic [5:0]             scroll_dist;
  logic [10*N_PLAT-1:0]   Platform_X;
  logic [10*N_PLAT-1:0]   Platform_Y;
  logic [N_PLAT-1:0]      respawned;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output frame_clk, hold, scroll_dist,
    input  Platform_X, Platform_Y, respawned, frame_done, overrun
  );

  modport slave (
    input  frame_clk, hold, scroll_dist,
    output Platform_X, Platform_Y, respawned, frame_done, overrun
  );
endinterface

// File: rtl/platform_field.sv
// rtl/platform_field.sv - bouncing, scrolling, respawning platform manager
// Updates one platform per cycle into working registers, then commits all at once.
module platform_field #(
  parameter int          N_PLAT    = 8,
  parameter int          H         = 240,
  parameter int          X_MIN     = 80,
  parameter int          X_MAX     = 239,
  parameter int          HALF      = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic            Clk,
  input logic            Reset_n,
  platform_field_if.slave pf
);
  localparam int LO   = X_MIN + HALF;
  localparam int HI   = X_MAX - HALF;
  localparam int SPAN = HI - LO + 1;
  localparam int RW   = $clog2(SPAN);
  localparam int IW   = $clog2(N_PLAT);
  localparam logic signed [10:0] LO_S = 11'(LO);
  localparam logic signed [10:0] HI_S = 11'(HI);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [5:0]         sc;
  logic [15:0]        lfsr;
  logic               fs1, fs2, fs_prev;
  logic               tick;
  logic               frame_done_q, overrun_q;

  logic [9:0]         wx [N_PLAT];
  logic [9:0]         wy [N_PLAT];
  logic signed [2:0]  wv [N_PLAT];
  logic [N_PLAT-1:0]  wr;
  logic [9:0]         ox [N_PLAT];
  logic [9:0]         oy [N_PLAT];
  logic [N_PLAT-1:0]  orsp;

  logic [9:0]         cur_x, cur_y;
  logic signed [2:0]  cur_v;
  logic signed [10:0] xn;
  logic [10:0]        yn;
  logic               respawn;
  logic [9:0]         r10;
  logic [1:0]         mag;
  logic [9:0]         nx, ny;
  logic signed [2:0]  nv;
  logic [15:0]        lfsr_next;

  assign tick = fs2 & ~fs_prev;
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_comb begin
    cur_x = wx[idx];
    cur_y = wy[idx];
    cur_v = wv[idx];
    xn    = $signed({1'b0, cur_x}) + $signed({{8{cur_v[2]}}, cur_v});
    nx    = xn[9:0];
    nv    = cur_v;
    if (xn >= HI_S) begin
      nx = 10'(HI);
      nv = -cur_v;
    end else if (xn <= LO_S) begin
      nx = 10'(LO);
      nv = -cur_v;
    end
    yn      = {1'b0, cur_y} + {5'b0, sc};
    respawn = yn > 11'(H - 1);
    ny      = yn[9:0];
    r10     = 10'(lfsr[RW-1:0]);
    if (r10 >= 10'(SPAN)) r10 = r10 - 10'(SPAN);
    mag = (lfsr[9:8] == 2'd0) ? 2'd1 : lfsr[9:8];
    // Respawn overrides any wall bounce computed above.
    if (respawn) begin
      ny = 10'(yn - 11'(H));
      nx = 10'(LO) + r10;
      nv = lfsr[10] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      sc           <= '0;
      lfsr         <= LFSR_SEED;
      fs1          <= 1'b0;
      fs2          <= 1'b0;
      fs_prev      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr           <= '0;
      orsp         <= '0;
      for (int i = 0; i < N_PLAT; i++) begin
        wx[i] <= 10'(LO + (i * 37) % SPAN);
        wy[i] <= 10'((H - 1) - i * (H / N_PLAT));
        wv[i] <= (i % 2 == 0) ? 3'sd1 : -3'sd1;
        ox[i] <= 10'(LO + (i * 37) % SPAN);
        oy[i] <= 10'((H - 1) - i * (H / N_PLAT));
      end
    end else begin
      fs1          <= pf.frame_clk;
      fs2          <= fs1;
      fs_prev      <= fs2;
      frame_done_q <= 1'b0;
      overrun_q    <= tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (tick && !pf.hold) begin
            sc    <= pf.scroll_dist;
            idx   <= '0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          wx[idx] <= nx;
          wy[idx] <= ny;
          wv[idx] <= nv;
          wr[idx] <= respawn;
          if (respawn) lfsr <= lfsr_next;
          if (idx == IW'(N_PLAT - 1)) state <= COMMIT;
          else idx <= idx + 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < N_PLAT; i++) begin
            ox[i] <= wx[i];
            oy[i] <= wy[i];
          end
          orsp         <= wr;
          frame_done_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_PLAT; g++) begin : g_out
    assign pf.Platform_X[10*g +: 10] = ox[g];
    assign pf.Platform_Y[10*g +: 10] = oy[g];
  end
  assign pf.respawned  = orsp;
  assign pf.frame_done = frame_done_q;
  assign pf.overrun    = overrun_q;
endmodule
